l2_responder: RTL and testbench

- Memory-side responder for the L2 request interface driven by the cache arbiter. It receives l2_read / l2_write / l2_address / l2_wdata and returns a single-cycle l2_resp.
- Backs requests with an internal line-granular storage array after a fixed programmable latency.
- Used as the L2/physical-memory model under the arbiter in simulation, and as the on-chip line store in small builds.

---
 rtl/l2_responder.sv | 191 +++++++++++++++++++
 tb/tb_l2_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_responder.sv
// ---------------------------------------------------------------------------
// l2_responder
//
// Memory-side responder for the L2 request interface driven by the cache
// arbiter. Each accepted request is backed by an internal line-granular
// storage array and completes after a fixed, programmable latency with a
// single-cycle l2_resp pulse.
//
// Parameters:
//   LATENCY    - cycles from request acceptance to l2_resp (legal 1..15)
//   INDEX_BITS - log2 of the number of 16-byte lines
//   LINE_BITS  - line width in bits
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   l2_read     in   read request, held by the initiator until l2_resp
//   l2_write    in   write request, held by the initiator until l2_resp
//   l2_address  in   byte address; [3:0] ignored, [3+INDEX_BITS:4] = line index
//   l2_wdata    in   write line, sampled at acceptance
//   l2_resp     out  one-cycle completion pulse
//   l2_rdata    out  read line, valid with l2_resp, held until the next read
//   busy        out  high whenever the FSM is not in IDLE
//   proto_err   out  sticky protocol-violation flag, cleared only by rst
//
// Optional build macro:
//   L2_RESP_STALL_EN - adds 0..3 pseudo-random stall cycles per request,
//                      drawn from an 8-bit Fibonacci LFSR.
// ---------------------------------------------------------------------------

// Handshake: the initiator raises l2_read or l2_write and holds it until the
// cycle in which l2_resp is high. The request is accepted at the first clock
// edge that finds the FSM in IDLE; address, operation and write data are
// captured there and later changes are ignored. Releasing the request before
// l2_resp is a protocol error, but the captured operation still completes.

module l2_responder #(
    parameter int LATENCY    = 4,
    parameter int INDEX_BITS = 5,
    parameter int LINE_BITS  = 128
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 l2_read,
    input  logic                 l2_write,
    input  logic [15:0]          l2_address,
    input  logic [LINE_BITS-1:0] l2_wdata,
    output logic                 l2_resp,
    output logic [LINE_BITS-1:0] l2_rdata,
    output logic                 busy,
    output logic                 proto_err
);

    localparam int LINES = 1 << INDEX_BITS;
    // Wide enough for LATENCY-1 plus up to 3 stall cycles.
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   op_write_q, op_write_d;
    logic [INDEX_BITS-1:0]  idx_q, idx_d;
    logic [LINE_BITS-1:0]   wdata_q, wdata_d;
    logic [LINE_BITS-1:0]   rdata_q, rdata_d;
    logic                   proto_err_q, proto_err_d;

    logic [LINE_BITS-1:0]   mem_q [LINES];

    logic                   req;
    logic [CNT_W-1:0]       load_val;

    // Offset bits and address bits above the index alias by design.
    logic                   unused_addr_bits;
    assign unused_addr_bits = ^{l2_address[3:0], l2_address[15:4+INDEX_BITS]};

    assign req = l2_read | l2_write;

`ifdef L2_RESP_STALL_EN
    logic [7:0] lfsr_q, lfsr_d;

    // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), shifting toward the MSB.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= 8'hA5;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign load_val = CNT_W'(LATENCY - 1) + {{(CNT_W-2){1'b0}}, lfsr_q[1:0]};

    logic unused_lfsr_bits;
    assign unused_lfsr_bits = ^lfsr_q[7:2];
`else
    assign load_val = CNT_W'(LATENCY - 1);
`endif

    // The counter holds the number of WAIT cycles still to go, so a request
    // spends 1 IDLE + load_val WAIT + 1 RESP cycles and a held request is
    // re-accepted every LATENCY+1 cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_write_d  = op_write_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        proto_err_d = proto_err_q;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    // Simultaneous read and write is resolved as a write.
                    op_write_d = l2_write;
                    idx_d      = l2_address[3+INDEX_BITS:4];
                    wdata_d    = l2_wdata;
                    cnt_d      = load_val;
                    if (l2_read && l2_write) begin
                        proto_err_d = 1'b1;
                    end
                    state_d = (load_val == '0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req) begin
                    proto_err_d = 1'b1;
                end
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Load read data on entry to RESP so it is visible alongside l2_resp.
        // Any earlier write has already committed at the end of its own RESP.
        if (state_d == ST_RESP && !op_write_d) begin
            rdata_d = mem_q[idx_d];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_write_q  <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_write_q  <= op_write_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Array contents survive reset; a reset in RESP suppresses the commit.
    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_RESP && op_write_q) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign l2_resp   = (state_q == ST_RESP);
    assign l2_rdata  = rdata_q;
    assign busy      = (state_q != ST_IDLE);
    assign proto_err = proto_err_q;

endmodule

// File: tb/tb_l2_responder.sv
module tb_l2_responder;

    localparam int LAT = 4;
    localparam int LB  = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          l2_read;
    logic          l2_write;
    logic [15:0]   l2_address;
    logic [LB-1:0] l2_wdata;
    logic          l2_resp;
    logic [LB-1:0] l2_rdata;
    logic          busy;
    logic          proto_err;

    l2_responder #(.LATENCY(LAT), .INDEX_BITS(5), .LINE_BITS(LB)) dut (
        .clk        (clk),
        .rst        (rst),
        .l2_read    (l2_read),
        .l2_write   (l2_write),
        .l2_address (l2_address),
        .l2_wdata   (l2_wdata),
        .l2_resp    (l2_resp),
        .l2_rdata   (l2_rdata),
        .busy       (busy),
        .proto_err  (proto_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;

    logic [LB-1:0] exp_q[$];
    bit            exp_rd_q[$];
    int            exp_cyc_q[$];
    int            lat_log[$];

    localparam logic [LB-1:0] D_0123 = {2{64'h0123_4567_89AB_CDEF}};
    localparam logic [LB-1:0] D_AAAA = {8{16'hAAAA}};
    localparam logic [LB-1:0] D_5555 = {8{16'h5555}};
    localparam logic [LB-1:0] D_1111 = {8{16'h1111}};
    localparam logic [LB-1:0] D_3333 = {8{16'h3333}};
    localparam logic [LB-1:0] D_DEAD = {8{16'hDEAD}};
    localparam logic [LB-1:0] D_7777 = {8{16'h7777}};

    task automatic check(input string name, input logic [LB-1:0] act,
                         input logic [LB-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per l2_resp pulse.
    always @(negedge clk) begin : monitor
        logic [LB-1:0] e;
        bit            rd;
        int            ic;
        int            lat;
        if (rst === 1'b0 && l2_resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_resp: got l2_resp=1 expected 0 (cycle %0d)", cyc);
            end else begin
                e   = exp_q.pop_front();
                rd  = exp_rd_q.pop_front();
                ic  = exp_cyc_q.pop_front();
                lat = cyc - ic;
                lat_log.push_back(lat);
`ifdef L2_RESP_STALL_EN
                n_cmp++;
                if (lat < LAT || lat > LAT + 3) begin
                    n_err++;
                    $display("FAIL resp_latency_range: got %0d expected %0d..%0d", lat, LAT, LAT + 3);
                end
`else
                check("resp_latency", LB'(lat), LB'(LAT));
`endif
                if (rd) begin
                    check("rdata", l2_rdata, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle_bus();
        l2_read    = 1'b0;
        l2_write   = 1'b0;
        l2_address = 16'h0000;
        l2_wdata   = '0;
    endtask

    task automatic drive_req(input bit rd, input bit wr, input logic [15:0] a,
                             input logic [LB-1:0] wd);
        l2_read    = rd;
        l2_write   = wr;
        l2_address = a;
        l2_wdata   = wd;
    endtask

    task automatic expect_resp(input bit rd, input logic [LB-1:0] e, input int ic);
        exp_q.push_back(e);
        exp_rd_q.push_back(rd);
        exp_cyc_q.push_back(ic);
    endtask

    task automatic wait_resp(output int rc);
        rc = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (l2_resp === 1'b1) begin
                rc = cyc;
                break;
            end
        end
        if (rc < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL resp_timeout: got no l2_resp expected one within 60 cycles");
        end
    endtask

    task automatic do_op(input bit rd, input bit wr, input logic [15:0] a,
                         input logic [LB-1:0] wd, input logic [LB-1:0] exp_rdata);
        int rc;
        @(negedge clk);
        drive_req(rd, wr, a, wd);
        expect_resp(rd && !wr, exp_rdata, cyc);
        wait_resp(rc);
        idle_bus();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_bus();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset_state();
        check("reset_l2_resp", LB'(l2_resp), LB'(0));
        check("reset_l2_rdata", l2_rdata, '0);
        check("reset_busy", LB'(busy), LB'(0));
        check("reset_proto_err", LB'(proto_err), LB'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int r1;
        int r2;
        int n0;
        int seen;
`ifdef L2_RESP_STALL_EN
        int run_a[$];
        int diffs;
`endif
        rst = 1'b1;
        idle_bus();
        do_reset();
        check_reset_state();

        // Basic write then read of one line.
        do_op(1'b0, 1'b1, 16'h0040, D_0123, '0);
        do_op(1'b1, 1'b0, 16'h0040, '0, D_0123);
        check("proto_err_after_basic", LB'(proto_err), LB'(0));

`ifndef L2_RESP_STALL_EN
        // Read held across l2_resp: re-accepted right after, spacing LAT+1.
        @(negedge clk);
        drive_req(1'b1, 1'b0, 16'h0040, '0);
        expect_resp(1'b1, D_0123, cyc);
        wait_resp(r1);
        expect_resp(1'b1, D_0123, r1 + 1);
        @(negedge clk);
        check("busy_idle_between", LB'(busy), LB'(0));
        @(negedge clk);
        check("busy_after_accept", LB'(busy), LB'(1));
        wait_resp(r2);
        idle_bus();
        check("resp_spacing", LB'(r2 - r1), LB'(LAT + 1));
        check("proto_err_after_held", LB'(proto_err), LB'(0));
`endif

        // Index aliasing: 0x0010 and 0x0210 share a line.
        do_op(1'b0, 1'b1, 16'h0010, D_AAAA, '0);
        do_op(1'b0, 1'b1, 16'h0210, D_5555, '0);
        do_op(1'b1, 1'b0, 16'h0010, '0, D_5555);

        // Reset during WAIT discards the pending write.
        do_op(1'b0, 1'b1, 16'h0030, D_3333, '0);
        @(negedge clk);
        drive_req(1'b0, 1'b1, 16'h0030, D_DEAD);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle_bus();
        check("busy_after_mid_rst", LB'(busy), LB'(0));
        check("proto_err_after_mid_rst", LB'(proto_err), LB'(0));
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (l2_resp === 1'b1) seen++;
        end
        check("no_resp_after_mid_rst", LB'(seen), LB'(0));
        do_op(1'b1, 1'b0, 16'h0030, '0, D_3333);

        // Request dropped and address/wdata changed during WAIT.
        @(negedge clk);
        drive_req(1'b0, 1'b1, 16'h0050, D_7777);
        expect_resp(1'b0, '0, cyc);
        n0 = cyc;
        @(negedge clk);
        drive_req(1'b0, 1'b0, 16'h0090, '0);
        wait_resp(r1);
        check("proto_err_after_drop", LB'(proto_err), LB'(1));
        do_op(1'b1, 1'b0, 16'h0050, '0, D_7777);
        check("proto_err_sticky_drop", LB'(proto_err), LB'(1));
        do_reset();
        check_reset_state();

        // Read and write together: resolved as a write, flags proto_err.
        do_op(1'b1, 1'b1, 16'h0080, D_1111, '0);
        check("proto_err_both", LB'(proto_err), LB'(1));
        do_op(1'b1, 1'b0, 16'h0080, '0, D_1111);
        check("proto_err_stays", LB'(proto_err), LB'(1));

`ifdef L2_RESP_STALL_EN
        // Stall pattern is repeatable for identical reset timing.
        do_reset();
        lat_log.delete();
        for (int i = 0; i < 100; i++) do_op(1'b1, 1'b0, 16'h0080, '0, D_1111);
        run_a = lat_log;
        do_reset();
        lat_log.delete();
        for (int i = 0; i < 100; i++) do_op(1'b1, 1'b0, 16'h0080, '0, D_1111);
        diffs = 0;
        for (int i = 0; i < 100; i++) begin
            if (i >= run_a.size() || i >= lat_log.size() || run_a[i] != lat_log[i]) diffs++;
        end
        check("stall_repeatable_diffs", LB'(diffs), LB'(0));
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", LB'(exp_q.size()), LB'(0));
        if (n0 < 0) $display("note: n0 %0d", n0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
